// File: rtl/mem_stage_ws.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ws
//  Description : Pipeline memory stage with a ready/acknowledge data bus,
//                unbounded wait states, optional timeout, byte-lane steering,
//                misalignment detection and fault reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ws #(
    parameter int          XLEN     = 32,
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                CLK,
    input  logic                RESn,
    input  logic                HLT,
    input  logic [XLEN-1:0]     EX_MEM_pc,
    input  logic [31:0]         EX_MEM_inst,
    input  logic [XLEN-1:0]     EX_MEM_alu,
    input  logic [4:0]          EX_MEM_rd,
    input  logic [XLEN-1:0]     EX_MEM_rs2,
    input  logic                EX_MEM_is_load,
    input  logic                EX_MEM_is_store,
    input  logic                EX_MEM_is_sys,
    input  logic [XLEN-1:0]     EX_MEM_csr_data,
    input  logic [XLEN-1:0]     DATAI,
    input  logic                DACK,
    output logic [XLEN-1:0]     DADDR,
    output logic [XLEN-1:0]     DATAO,
    output logic [XLEN/8-1:0]   DBE,
    output logic                DRD,
    output logic                DWR,
    output logic                DAS,
    output logic                MEM_STALL,
    output logic [31:0]         MEM_WB_inst,
    output logic [XLEN-1:0]     MEM_WB_pc,
    output logic [XLEN-1:0]     MEM_WB_data,
    output logic [XLEN-1:0]     MEM_WB_alu,
    output logic [4:0]          MEM_WB_rd,
    output logic                MEM_WB_valid,
    output logic                MEM_FAULT,
    output logic [1:0]          MEM_FAULT_cause,
    output logic [XLEN-1:0]     MEM_FAULT_addr
);

    localparam int c_NL = XLEN / 8;
    localparam int c_OW = $clog2(c_NL);
    localparam int c_CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TO = c_CW'(TIMEOUT);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_WAIT = 1'b1;

    localparam logic [1:0] c_CAUSE_LD  = 2'b01;
    localparam logic [1:0] c_CAUSE_ST  = 2'b10;
    localparam logic [1:0] c_CAUSE_TO  = 2'b11;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [c_CW-1:0]  r_cnt;

    logic [1:0]       w_sz;
    logic [c_OW-1:0]  w_off;
    logic [c_OW-1:0]  w_size_mask;
    logic [c_NL-1:0]  w_lane_mask;
    logic             w_is_access;
    logic             w_misaligned;
    logic             w_timeout_hit;
    logic             w_das_raw;
    logic             w_das;
    logic             w_drd;
    logic             w_dwr;
    logic             w_stall;
    logic [XLEN-1:0]  w_datao;
    logic [c_OW-1:0]  w_src;
    logic [XLEN-1:0]  w_lane;
    logic [XLEN-1:0]  w_load;
    logic [XLEN-1:0]  w_wb_data;
    logic             w_wb_en;
    logic             w_fault_mis;
    logic             w_fault_to;

    logic [31:0]      r_wb_inst;
    logic [XLEN-1:0]  r_wb_pc;
    logic [XLEN-1:0]  r_wb_data;
    logic [XLEN-1:0]  r_wb_alu;
    logic [4:0]       r_wb_rd;
    logic             r_wb_valid;
    logic             r_fault;
    logic [1:0]       r_fault_cause;
    logic [XLEN-1:0]  r_fault_addr;

    assign w_is_access = EX_MEM_is_load | EX_MEM_is_store;
    assign w_off       = EX_MEM_alu[c_OW-1:0];

    // Decode access size; a doubleword on a 32-bit datapath degrades to word
    always_comb begin
        w_sz = EX_MEM_inst[13:12];
        if (XLEN == 32 && w_sz == 2'b11) begin
            w_sz = 2'b10;
        end
        w_size_mask = '0;
        w_lane_mask = c_NL'(8'h01);
        case (w_sz)
            2'b00: begin
                w_size_mask = '0;
                w_lane_mask = c_NL'(8'h01);
            end
            2'b01: begin
                w_size_mask = c_OW'(3'd1);
                w_lane_mask = c_NL'(8'h03);
            end
            2'b10: begin
                w_size_mask = c_OW'(3'd3);
                w_lane_mask = c_NL'(8'h0F);
            end
            default: begin
                w_size_mask = c_OW'(3'd7);
                w_lane_mask = c_NL'(8'hFF);
            end
        endcase
        w_misaligned = |(w_off & w_size_mask);
    end

    // Replicate the store sub-word across every lane; the byte enables pick the live ones
    always_comb begin
        w_datao = '0;
        w_src   = '0;
        for (int i = 0; i < c_NL; i++) begin
            w_src = c_OW'(i) & w_size_mask;
            w_datao[8*i +: 8] = EX_MEM_rs2[{w_src, 3'b000} +: 8];
        end
    end

    // Shift the addressed lane down and extend it to the full datapath width
    always_comb begin
        w_lane = DATAI >> {w_off, 3'b000};
        case (w_sz)
            2'b00:   w_load = EX_MEM_inst[14] ? XLEN'(w_lane[7:0])
                                              : XLEN'($signed(w_lane[7:0]));
            2'b01:   w_load = EX_MEM_inst[14] ? XLEN'(w_lane[15:0])
                                              : XLEN'($signed(w_lane[15:0]));
            2'b10:   w_load = EX_MEM_inst[14] ? XLEN'(w_lane[31:0])
                                              : XLEN'($signed(w_lane[31:0]));
            default: w_load = w_lane;
        endcase
        if (EX_MEM_is_load) begin
            w_wb_data = w_load;
        end else if (EX_MEM_is_sys) begin
            w_wb_data = EX_MEM_csr_data;
        end else begin
            w_wb_data = EX_MEM_alu;
        end
    end

    assign w_timeout_hit = (TIMEOUT != 0) && (r_state == c_S_WAIT) && (r_cnt == c_TO);

    // FSM state register
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            r_state <= c_S_IDLE;
        end else if (!HLT) begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: acknowledge takes priority over the timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_is_access && !w_misaligned && !DACK) begin
                    w_state_nxt = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (DACK || w_timeout_hit) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // FSM outputs: bus strobes are killed combinationally while reset is asserted
    always_comb begin
        w_das_raw = 1'b0;
        case (r_state)
            c_S_IDLE: w_das_raw = w_is_access && !w_misaligned;
            c_S_WAIT: w_das_raw = 1'b1;
            default:  w_das_raw = 1'b0;
        endcase
        w_das   = w_das_raw & RESn;
        w_drd   = w_das & EX_MEM_is_load;
        w_dwr   = w_das & EX_MEM_is_store;
        w_stall = w_das & ~DACK & ~w_timeout_hit;
    end

    // Wait-state counter runs only while an access is still pending in WAIT
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            r_cnt <= '0;
        end else if (!HLT) begin
            if (r_state == c_S_WAIT && !DACK && !w_timeout_hit) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Classify what the MEM/WB register receives at the next edge
    always_comb begin
        w_wb_en     = ((r_state == c_S_IDLE) && !w_is_access) || (w_das_raw && DACK);
        w_fault_mis = (r_state == c_S_IDLE) && w_is_access && w_misaligned;
        w_fault_to  = w_timeout_hit && !DACK;
    end

    // MEM/WB pipeline register and fault reporting
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            r_wb_inst     <= '0;
            r_wb_pc       <= '0;
            r_wb_data     <= '0;
            r_wb_alu      <= '0;
            r_wb_rd       <= '0;
            r_wb_valid    <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= '0;
            r_fault_addr  <= '0;
        end else if (!HLT) begin
            r_wb_pc  <= EX_MEM_pc;
            r_wb_alu <= EX_MEM_alu;
            r_fault  <= 1'b0;
            if (w_wb_en) begin
                r_wb_inst  <= EX_MEM_inst;
                r_wb_data  <= w_wb_data;
                r_wb_rd    <= EX_MEM_rd;
                r_wb_valid <= 1'b1;
            end else begin
                // Stalled or faulting cycles hand a bubble to writeback
                r_wb_inst  <= NOP_INST;
                r_wb_data  <= '0;
                r_wb_rd    <= '0;
                r_wb_valid <= 1'b0;
            end
            if (w_fault_mis) begin
                r_fault       <= 1'b1;
                r_fault_cause <= EX_MEM_is_load ? c_CAUSE_LD : c_CAUSE_ST;
                r_fault_addr  <= EX_MEM_alu;
            end else if (w_fault_to) begin
                r_fault       <= 1'b1;
                r_fault_cause <= c_CAUSE_TO;
                r_fault_addr  <= EX_MEM_alu;
            end
        end
    end

    assign DADDR           = {EX_MEM_alu[XLEN-1:c_OW], {c_OW{1'b0}}};
    assign DATAO           = w_datao;
    assign DBE             = w_das ? (w_lane_mask << w_off) : '0;
    assign DAS             = w_das;
    assign DRD             = w_drd;
    assign DWR             = w_dwr;
    assign MEM_STALL       = w_stall;
    assign MEM_WB_inst     = r_wb_inst;
    assign MEM_WB_pc       = r_wb_pc;
    assign MEM_WB_data     = r_wb_data;
    assign MEM_WB_alu      = r_wb_alu;
    assign MEM_WB_rd       = r_wb_rd;
    assign MEM_WB_valid    = r_wb_valid;
    assign MEM_FAULT       = r_fault;
    assign MEM_FAULT_cause = r_fault_cause;
    assign MEM_FAULT_addr  = r_fault_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ws.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_ws
//  Description : Directed self-checking bench for mem_stage_ws, one 32-bit
//                instance (TIMEOUT=4) and one 64-bit instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ws;

    localparam logic [6:0] c_OP_LD  = 7'b0000011;
    localparam logic [6:0] c_OP_ST  = 7'b0100011;
    localparam logic [6:0] c_OP_ALU = 7'b0110011;

    logic CLK = 1'b0;
    logic RESn = 1'b0;
    logic hlt = 1'b0;
    int   total = 0;
    int   bad = 0;

    // 32-bit instance signals
    logic [31:0] a_pc, a_inst, a_alu, a_rs2, a_csr, a_datai;
    logic [4:0]  a_rd;
    logic        a_ld, a_st, a_sys, a_dack;
    logic [31:0] a_daddr, a_datao, a_wb_inst, a_wb_pc, a_wb_data, a_wb_alu, a_faddr;
    logic [3:0]  a_dbe;
    logic        a_drd, a_dwr, a_das, a_stall, a_wb_valid, a_flt;
    logic [4:0]  a_wb_rd;
    logic [1:0]  a_cause;

    // 64-bit instance signals
    logic [63:0] b_pc, b_alu, b_rs2, b_csr, b_datai;
    logic [31:0] b_inst;
    logic [4:0]  b_rd;
    logic        b_ld, b_st, b_sys, b_dack;
    logic [63:0] b_daddr, b_datao, b_wb_pc, b_wb_data, b_wb_alu, b_faddr;
    logic [31:0] b_wb_inst;
    logic [7:0]  b_dbe;
    logic        b_drd, b_dwr, b_das, b_stall, b_wb_valid, b_flt;
    logic [4:0]  b_wb_rd;
    logic [1:0]  b_cause;

    mem_stage_ws #(.XLEN(32), .TIMEOUT(4), .NOP_INST(32'h00000013)) dut32 (
        .CLK(CLK), .RESn(RESn), .HLT(hlt),
        .EX_MEM_pc(a_pc), .EX_MEM_inst(a_inst), .EX_MEM_alu(a_alu), .EX_MEM_rd(a_rd),
        .EX_MEM_rs2(a_rs2), .EX_MEM_is_load(a_ld), .EX_MEM_is_store(a_st),
        .EX_MEM_is_sys(a_sys), .EX_MEM_csr_data(a_csr),
        .DATAI(a_datai), .DACK(a_dack),
        .DADDR(a_daddr), .DATAO(a_datao), .DBE(a_dbe),
        .DRD(a_drd), .DWR(a_dwr), .DAS(a_das), .MEM_STALL(a_stall),
        .MEM_WB_inst(a_wb_inst), .MEM_WB_pc(a_wb_pc), .MEM_WB_data(a_wb_data),
        .MEM_WB_alu(a_wb_alu), .MEM_WB_rd(a_wb_rd), .MEM_WB_valid(a_wb_valid),
        .MEM_FAULT(a_flt), .MEM_FAULT_cause(a_cause), .MEM_FAULT_addr(a_faddr)
    );

    mem_stage_ws #(.XLEN(64), .TIMEOUT(15), .NOP_INST(32'h00000013)) dut64 (
        .CLK(CLK), .RESn(RESn), .HLT(hlt),
        .EX_MEM_pc(b_pc), .EX_MEM_inst(b_inst), .EX_MEM_alu(b_alu), .EX_MEM_rd(b_rd),
        .EX_MEM_rs2(b_rs2), .EX_MEM_is_load(b_ld), .EX_MEM_is_store(b_st),
        .EX_MEM_is_sys(b_sys), .EX_MEM_csr_data(b_csr),
        .DATAI(b_datai), .DACK(b_dack),
        .DADDR(b_daddr), .DATAO(b_datao), .DBE(b_dbe),
        .DRD(b_drd), .DWR(b_dwr), .DAS(b_das), .MEM_STALL(b_stall),
        .MEM_WB_inst(b_wb_inst), .MEM_WB_pc(b_wb_pc), .MEM_WB_data(b_wb_data),
        .MEM_WB_alu(b_wb_alu), .MEM_WB_rd(b_wb_rd), .MEM_WB_valid(b_wb_valid),
        .MEM_FAULT(b_flt), .MEM_FAULT_cause(b_cause), .MEM_FAULT_addr(b_faddr)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
        return {17'd0, f3, 5'd0, opc};
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic a_idle(input logic [31:0] pc);
        a_pc = pc; a_inst = mk(3'b000, c_OP_ALU); a_alu = 32'h0; a_rd = 5'd0;
        a_rs2 = 32'h0; a_ld = 1'b0; a_st = 1'b0; a_sys = 1'b0; a_csr = 32'h0;
        a_datai = 32'h0; a_dack = 1'b0;
    endtask

    task automatic a_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc);
        a_idle(pc);
        a_ld = ld; a_st = st; a_alu = alu; a_rs2 = rs2; a_rd = 5'd7;
        a_inst = mk(f3, st ? c_OP_ST : c_OP_LD);
    endtask

    task automatic b_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] alu, input logic [63:0] rs2, input logic [63:0] datai);
        b_pc = 64'h100; b_rd = 5'd9; b_sys = 1'b0; b_csr = 64'h0; b_dack = 1'b1;
        b_ld = ld; b_st = st; b_alu = alu; b_rs2 = rs2; b_datai = datai;
        b_inst = mk(f3, st ? c_OP_ST : c_OP_LD);
    endtask

    task automatic test_reset;
        repeat (2) tick;
        total++; if (a_wb_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", a_wb_valid); end
        total++; if (a_wb_inst !== 32'h0) begin bad++; $display("FAIL rst_inst: got %h want 0", a_wb_inst); end
        total++; if (a_flt !== 1'b0 || a_cause !== 2'b00) begin bad++; $display("FAIL rst_fault: got %b/%b want 0/00", a_flt, a_cause); end
        total++; if (b_wb_valid !== 1'b0) begin bad++; $display("FAIL rst_valid64: got %b want 0", b_wb_valid); end
        RESn = 1'b1;
        a_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h20);
        tick;
        tick;
        total++; if (a_das !== 1'b1 || a_drd !== 1'b1) begin bad++; $display("FAIL wait_strobe: got das=%b drd=%b want 1/1", a_das, a_drd); end
        RESn = 1'b0;
        #1;
        total++; if (a_das !== 1'b0 || a_drd !== 1'b0 || a_stall !== 1'b0) begin
            bad++; $display("FAIL async_drop: got das=%b drd=%b stall=%b want 0/0/0", a_das, a_drd, a_stall);
        end
        tick;
        total++; if (a_wb_valid !== 1'b0) begin bad++; $display("FAIL abandon: got valid=%b want 0", a_wb_valid); end
        a_idle(32'h40);
        RESn = 1'b1;
        a_alu = 32'h1234; a_rd = 5'd5;
        tick;
        total++; if (a_wb_data !== 32'h1234 || a_wb_valid !== 1'b1 || a_wb_rd !== 5'd5) begin
            bad++; $display("FAIL alu_pass: got data=%h valid=%b rd=%0d want 1234/1/5", a_wb_data, a_wb_valid, a_wb_rd);
        end
    endtask

    task automatic test_sub_load;
        a_op(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h44);
        a_datai = 32'h80FF_0000; a_dack = 1'b1;
        #1;
        total++; if (a_dbe !== 4'b1000 || a_daddr !== 32'h1000) begin
            bad++; $display("FAIL lb_bus: got dbe=%b addr=%h want 1000/00001000", a_dbe, a_daddr);
        end
        total++; if (a_stall !== 1'b0 || a_das !== 1'b1) begin bad++; $display("FAIL lb_stall: got stall=%b das=%b want 0/1", a_stall, a_das); end
        tick;
        total++; if (a_wb_data !== 32'hFFFF_FF80 || a_wb_valid !== 1'b1) begin
            bad++; $display("FAIL lb_data: got %h valid=%b want ffffff80/1", a_wb_data, a_wb_valid);
        end
        a_inst = mk(3'b100, c_OP_LD);
        tick;
        total++; if (a_wb_data !== 32'h0000_0080) begin bad++; $display("FAIL lbu_data: got %h want 00000080", a_wb_data); end
        a_idle(32'h48);
    endtask

    task automatic test_wait_states;
        int stalls = 0;
        int wbs = 0;
        a_op(1'b0, 1'b1, 3'b010, 32'h2000, 32'hDEAD_BEEF, 32'h60);
        for (int c = 0; c < 6; c++) begin
            if (c < 4) a_dack = (c == 3);
            #1;
            if (a_stall === 1'b1) stalls++;
            if (c == 0) begin
                total++; if (a_dbe !== 4'b1111 || a_datao !== 32'hDEAD_BEEF || a_dwr !== 1'b1 || a_drd !== 1'b0) begin
                    bad++; $display("FAIL sw_bus: got dbe=%b datao=%h dwr=%b drd=%b want 1111/deadbeef/1/0", a_dbe, a_datao, a_dwr, a_drd);
                end
            end
            tick;
            if (a_wb_valid === 1'b1 && a_wb_pc === 32'h60) begin
                wbs++;
                total++; if (a_wb_data !== 32'h2000) begin bad++; $display("FAIL sw_wbdata: got %h want 00002000", a_wb_data); end
            end
            if (c == 3) a_idle(32'h64);
        end
        total++; if (stalls != 3) begin bad++; $display("FAIL sw_stall_cycles: got %0d want 3", stalls); end
        total++; if (wbs != 1) begin bad++; $display("FAIL sw_writebacks: got %0d want 1", wbs); end
    endtask

    task automatic test_misalign;
        a_op(1'b1, 1'b0, 3'b001, 32'h3001, 32'h0, 32'h70);
        #1;
        total++; if (a_das !== 1'b0 || a_stall !== 1'b0) begin bad++; $display("FAIL lh_mis_bus: got das=%b stall=%b want 0/0", a_das, a_stall); end
        tick;
        total++; if (a_flt !== 1'b1 || a_cause !== 2'b01 || a_faddr !== 32'h3001) begin
            bad++; $display("FAIL lh_mis_fault: got flt=%b cause=%b addr=%h want 1/01/00003001", a_flt, a_cause, a_faddr);
        end
        total++; if (a_wb_inst !== 32'h13 || a_wb_valid !== 1'b0) begin
            bad++; $display("FAIL lh_mis_bubble: got inst=%h valid=%b want 00000013/0", a_wb_inst, a_wb_valid);
        end
        a_op(1'b0, 1'b1, 3'b010, 32'h3002, 32'h1, 32'h74);
        tick;
        total++; if (a_flt !== 1'b1 || a_cause !== 2'b10 || a_faddr !== 32'h3002) begin
            bad++; $display("FAIL sw_mis_fault: got flt=%b cause=%b addr=%h want 1/10/00003002", a_flt, a_cause, a_faddr);
        end
        a_idle(32'h78);
        tick;
        total++; if (a_flt !== 1'b0) begin bad++; $display("FAIL fault_clear: got %b want 0", a_flt); end
    endtask

    task automatic test_timeout;
        int stalls = 0;
        int seen_at = -1;
        a_op(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h80);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (a_stall === 1'b1) stalls++;
            tick;
            if (a_flt === 1'b1) begin
                seen_at = c;
                break;
            end
        end
        total++; if (seen_at != 5) begin bad++; $display("FAIL to_fault_edge: got %0d want 5", seen_at); end
        total++; if (stalls != 5) begin bad++; $display("FAIL to_stall_cycles: got %0d want 5", stalls); end
        total++; if (a_cause !== 2'b11 || a_wb_valid !== 1'b0 || a_wb_inst !== 32'h13) begin
            bad++; $display("FAIL to_bubble: got cause=%b valid=%b inst=%h want 11/0/00000013", a_cause, a_wb_valid, a_wb_inst);
        end
        a_idle(32'h84);
        tick;
        a_op(1'b1, 1'b0, 3'b010, 32'h4100, 32'h0, 32'h88);
        a_datai = 32'h55AA_1234;
        for (int c = 0; c < 6; c++) begin
            a_dack = (c == 5);
            #1;
            if (c == 5) begin
                total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL to_ack_stall: got %b want 0", a_stall); end
            end
            tick;
        end
        total++; if (a_flt !== 1'b0 || a_wb_valid !== 1'b1 || a_wb_data !== 32'h55AA_1234) begin
            bad++; $display("FAIL to_ack_wins: got flt=%b valid=%b data=%h want 0/1/55aa1234", a_flt, a_wb_valid, a_wb_data);
        end
        a_idle(32'h8C);
        tick;
    endtask

    task automatic test_hlt;
        a_op(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 32'h90);
        repeat (3) tick;
        hlt = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (a_das !== 1'b1 || a_stall !== 1'b1) begin bad++; $display("FAIL hlt_strobe: got das=%b stall=%b want 1/1", a_das, a_stall); end
            tick;
            total++; if (a_flt !== 1'b0 || a_wb_valid !== 1'b0) begin bad++; $display("FAIL hlt_hold: got flt=%b valid=%b want 0/0", a_flt, a_wb_valid); end
        end
        hlt = 1'b0;
        tick;
        tick;
        total++; if (a_flt !== 1'b0) begin bad++; $display("FAIL hlt_counter_early: got flt=%b want 0", a_flt); end
        tick;
        total++; if (a_flt !== 1'b1 || a_cause !== 2'b11) begin bad++; $display("FAIL hlt_counter_resume: got flt=%b cause=%b want 1/11", a_flt, a_cause); end
        a_idle(32'h94);
        hlt = 1'b1;
        tick;
        total++; if (a_flt !== 1'b1 || a_wb_valid !== 1'b0) begin bad++; $display("FAIL hlt_freeze_regs: got flt=%b valid=%b want 1/0", a_flt, a_wb_valid); end
        hlt = 1'b0;
        tick;
        total++; if (a_flt !== 1'b0 || a_wb_valid !== 1'b1) begin bad++; $display("FAIL hlt_release: got flt=%b valid=%b want 0/1", a_flt, a_wb_valid); end
    endtask

    task automatic test_xlen64;
        b_op(1'b1, 1'b0, 3'b011, 64'h8, 64'h0, 64'h0123_4567_89AB_CDEF);
        #1;
        total++; if (b_dbe !== 8'hFF || b_daddr !== 64'h8 || b_stall !== 1'b0) begin
            bad++; $display("FAIL ld64_bus: got dbe=%h addr=%h stall=%b want ff/8/0", b_dbe, b_daddr, b_stall);
        end
        tick;
        total++; if (b_wb_data !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL ld64_data: got %h want 0123456789abcdef", b_wb_data); end
        b_op(1'b1, 1'b0, 3'b010, 64'hC, 64'h0, 64'h8000_0000_0000_0000);
        #1;
        total++; if (b_dbe !== 8'hF0 || b_daddr !== 64'h8) begin bad++; $display("FAIL lw64_bus: got dbe=%h addr=%h want f0/8", b_dbe, b_daddr); end
        tick;
        total++; if (b_wb_data !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL lw64_data: got %h want ffffffff80000000", b_wb_data); end
        b_op(1'b0, 1'b1, 3'b000, 64'h5, 64'h1234_56AB, 64'h0);
        #1;
        total++; if (b_dbe !== 8'h20 || b_datao !== 64'hABAB_ABAB_ABAB_ABAB) begin
            bad++; $display("FAIL sb64_bus: got dbe=%h datao=%h want 20/abababababababab", b_dbe, b_datao);
        end
        tick;
        total++; if (b_wb_data !== 64'h5 || b_wb_valid !== 1'b1) begin bad++; $display("FAIL sb64_wb: got data=%h valid=%b want 5/1", b_wb_data, b_wb_valid); end
    endtask

    initial begin
        a_idle(32'h0);
        b_pc = '0; b_inst = mk(3'b000, c_OP_ALU); b_alu = '0; b_rd = '0; b_rs2 = '0;
        b_ld = 1'b0; b_st = 1'b0; b_sys = 1'b0; b_csr = '0; b_datai = '0; b_dack = 1'b0;
        test_reset;
        test_sub_load;
        test_wait_states;
        test_misalign;
        test_timeout;
        test_hlt;
        test_xlen64;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_ws.md
Name: mem_stage_ws

Overview:
- Parametrised next-generation Memory stage of the 5-stage pipeline, between the EX/MEM and MEM/WB registers.
- Adds a bus-ready handshake with unbounded wait states, an optional timeout, and byte-lane steering for sub-word accesses.
- Detects misaligned accesses and reports faults.
- Stalls the upstream pipeline while a data-bus access is outstanding; delivers aligned, extended load data and CSR/ALU results to writeback.

Parameters:
- XLEN, 32: datapath and data-bus width; legal values 32 and 64. Byte lanes NL = XLEN/8.
- TIMEOUT, 15: wait-state limit before a bus-timeout fault; 0 disables the timeout.
- NOP_INST, 32'h00000013: instruction written into MEM_WB_inst for bubbles.

Ports:
- CLK  in  1  clock, rising edge
- RESn  in  1  asynchronous active-low reset
- HLT  in  1  global freeze; holds all state including the wait counter
- EX_MEM_pc  in  XLEN  PC of the instruction in MEM
- EX_MEM_inst  in  32  instruction; funct3 = inst[14:12]
- EX_MEM_alu  in  XLEN  ALU result / effective address
- EX_MEM_rd  in  5  destination register
- EX_MEM_rs2  in  XLEN  store data
- EX_MEM_is_load, EX_MEM_is_store, EX_MEM_is_sys  in  1 each  class flags; at most one is high
- EX_MEM_csr_data  in  XLEN  CSR read value
- DATAI  in  XLEN  bus read data, valid when DACK is high
- DACK  in  1  bus acknowledge
- DADDR  out  XLEN  address with the low log2(NL) bits cleared
- DATAO  out  XLEN  lane-steered store data
- DBE  out  NL  byte enables
- DRD, DWR, DAS  out  1 each  read strobe, write strobe, access strobe
- MEM_STALL  out  1  freeze IF/ID/EX and EX/MEM
- MEM_WB_inst  out  32;  MEM_WB_pc, MEM_WB_data, MEM_WB_alu  out  XLEN;  MEM_WB_rd  out  5;  MEM_WB_valid  out  1
- MEM_FAULT  out  1  one-cycle fault pulse, aligned with the MEM/WB update
- MEM_FAULT_cause  out  2  01 load misaligned, 10 store misaligned, 11 bus timeout
- MEM_FAULT_addr  out  XLEN  faulting effective address

Behaviour:
Reset:
- All MEM_WB_* registers 0, MEM_WB_valid 0, MEM_FAULT 0, cause 0, fault address 0.
- FSM in IDLE, wait counter 0.
- While RESn is low, the bus strobes DAS/DRD/DWR are forced 0 immediately, without waiting for a clock edge.
- Reset asserted mid-access abandons the access; no writeback occurs.

Access decode (access = is_load | is_store):
- funct3[1:0] gives size: 00 byte, 01 half, 10 word, 11 double (double legal only when XLEN=64; with XLEN=32 it is treated as word).
- funct3[2] selects zero-extension on loads.
- off = EX_MEM_alu[log2(NL)-1:0].
- Misaligned when off is not a multiple of the access size.

FSM states and transitions:
- IDLE, non-access:
  - No strobes.
  - Next edge (HLT=0): MEM_WB_data = is_sys ? csr_data : alu; remaining MEM_WB_* copied from EX_MEM; valid=1.
- IDLE, misaligned access:
  - No strobes, no stall.
  - Next edge: bubble (inst=NOP_INST, rd=0, valid=0), MEM_FAULT=1 with cause 01/10, MEM_FAULT_addr=alu.
- IDLE, aligned access:
  - DAS=1 and DRD/DWR driven combinationally from the EX_MEM inputs in the same cycle.
  - DACK=1 in that cycle: zero-wait completion; writeback at the next edge.
  - DACK=0: go to WAIT at the next edge.
- WAIT:
  - Strobes held; EX_MEM inputs stay stable because MEM_STALL is asserted.
  - Counter increments each non-HLT cycle.
  - DACK=1: capture DATAI, write back, return to IDLE, counter cleared.
  - TIMEOUT≠0 and counter==TIMEOUT with DACK=0: drop the strobes, emit a bubble with fault cause 11, return to IDLE.
  - DACK and timeout in the same cycle: DACK wins.
- MEM_STALL = DAS & ~DACK & ~timeout_hit (combinational).
- HLT=1: no register, FSM or counter changes; strobes hold their current values.

Store datapath:
- DATAO = rs2 sub-word replicated across all lanes, so the active lanes carry rs2[8·size−1:0].
- DBE = ((1<<size_bytes)−1) << off.
- A store's MEM_WB_data is the ALU result.

Load datapath:
- lane_data = DATAI >> (8·off), truncated to the access size.
- Sign- or zero-extended to XLEN according to funct3[2].
- Registered into MEM_WB_data.

Additional rules:
- MEM_FAULT deasserts the cycle after its pulse unless a new fault occurs.
- MEM_WB_alu always carries the unmodified effective address.

Test Plan:
- Reset/ALU pass-through: RESn=0 mid-WAIT → DAS/DRD drop at once; after release, an ADD with alu=0x1234 and rd=5 gives MEM_WB_data=0x1234, valid=1 one cycle later.
- Sub-word load: LB at 0x1003 with DATAI=0x80FF_0000 (XLEN=32), DACK high same cycle → DBE=4'b1000, DADDR=0x1000, MEM_WB_data=0xFFFFFF80, no stall. Repeat as LBU → 0x00000080.
- Wait states: SW at 0x2000, rs2=0xDEADBEEF, DACK after 3 cycles → MEM_STALL high exactly 3 cycles, DBE=4'b1111, DATAO=0xDEADBEEF, single writeback.
- Misalign: LH at 0x3001 → no DAS, MEM_FAULT=1 with cause 01 and addr 0x3001, MEM_WB_inst=0x00000013, valid=0. SW at 0x3002 → cause 10.
- Timeout: TIMEOUT=4, DACK never asserted → stall for 5 cycles, then cause 11 and a bubble. Repeat with DACK arriving exactly on the timeout cycle → normal completion, no fault.
- HLT freeze and XLEN=64: HLT=1 for 2 cycles during WAIT → counter and outputs frozen. With XLEN=64, LD at 0x8 → DBE=8'hFF; LW at 0xC, DATAI=0x8000_0000_0000_0000 → MEM_WB_data=0xFFFFFFFF80000000.
